// File: rtl/mips_fetch_unit_pkg.sv
// Shared opcodes, fetch FSM states and next-PC helper for the MIPS fetch front end.
package mips_fetch_pkg;

   localparam logic [5:0] OP_RTYPE = 6'd0;
   localparam logic [5:0] OP_J     = 6'd2;
   localparam logic [5:0] OP_BEQ   = 6'd4;
   localparam logic [5:0] OP_LW    = 6'd35;
   localparam logic [5:0] OP_SW    = 6'd43;
   localparam logic [5:0] OP_HALT  = 6'd63;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_ISSUE,
      S_EXEC,
      S_HALT
   } fetch_state_e;

   // Sequential / jump / taken-beq target with 32-bit wrap-around.
   function automatic logic [31:0] next_pc(input logic [31:0] pc,
                                           input logic [31:0] instr,
                                           input logic        br_eq);
      logic [31:0] pc4;
      logic [31:0] off;
      logic [31:0] res;
      pc4 = pc + 32'd4;
      off = {{14{instr[15]}}, instr[15:0], 2'b00};
      res = pc4;
      if (instr[31:26] == OP_J)
         res = {pc4[31:28], instr[25:0], 2'b00};
      else if ((instr[31:26] == OP_BEQ) && br_eq)
         res = pc4 + off;
      return res;
   endfunction

endpackage

// File: rtl/mips_fetch_unit_if.sv
// Fetch unit bus: run/branch flag and imem load port in, instruction stream out.
interface mips_fetch_unit_if #(
   parameter int unsigned IMEM_DEPTH = 64
);
   localparam int unsigned AW = $clog2(IMEM_DEPTH);

   logic          run;
   logic          br_eq;
   logic          imem_we;
   logic [AW-1:0] imem_waddr;
   logic [31:0]   imem_wdata;
   logic [31:0]   instrword;
   logic          newinstr;
   logic [31:0]   pc;
   logic          halted;

   modport master (
      output run, br_eq, imem_we, imem_waddr, imem_wdata,
      input  instrword, newinstr, pc, halted
   );

   modport slave (
      input  run, br_eq, imem_we, imem_waddr, imem_wdata,
      output instrword, newinstr, pc, halted
   );

endinterface

// File: rtl/mips_fetch_unit_imem.sv
// Instruction RAM: one write port, synchronous read; same-cycle collision returns old data.
module fetch_imem #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [31:0]   wdata,
   input  logic [AW-1:0] raddr,
   output logic [31:0]   rdata
);

   logic [31:0] mem [DEPTH];

   // Write port.
   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   // Registered read port.
   always_ff @(posedge clk) begin
      rdata <= mem[raddr];
   end

endmodule

// File: rtl/mips_fetch_unit.sv
// Multi-cycle MIPS fetch unit: PC, instruction RAM, issue/exec window FSM.
// Optional feature macro: FETCH_BRANCH_EN enables j/beq redirection of the PC.
module mips_fetch_unit
   import mips_fetch_pkg::*;
#(
   parameter int unsigned IMEM_DEPTH  = 64,
   parameter int unsigned EXEC_CYCLES = 4,
   parameter logic [31:0] RESET_PC    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst,
   mips_fetch_unit_if.slave bus
);

   localparam int unsigned AW = $clog2(IMEM_DEPTH);
   localparam int unsigned CW = $clog2(EXEC_CYCLES + 1);

   fetch_state_e  state;
   logic [CW-1:0] cnt;
   logic [31:0]   pc_q;
   logic [31:0]   instr_q;
   logic          newinstr_q;
   logic          halted_q;
   logic [31:0]   rd_data;
   logic [31:0]   npc;
   logic [AW-1:0] rd_addr;
   logic          last_exec;

   // Final cycle of the execution window.
   assign last_exec = (state == S_EXEC) && (cnt == '0);

`ifdef FETCH_BRANCH_EN
   assign npc = next_pc(pc_q, instr_q, bus.br_eq);
`else
   assign npc = pc_q + 32'd4;
`endif

   // Read the upcoming PC so the word is ready by the time FETCH is entered.
   assign rd_addr = last_exec ? npc[AW+1:2] : pc_q[AW+1:2];

   fetch_imem #(.DEPTH(IMEM_DEPTH), .AW(AW)) u_imem (
      .clk   (clk),
      .we    (bus.imem_we),
      .waddr (bus.imem_waddr),
      .wdata (bus.imem_wdata),
      .raddr (rd_addr),
      .rdata (rd_data)
   );

   // Fetch FSM, window counter, PC and registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_IDLE;
         cnt        <= '0;
         pc_q       <= RESET_PC;
         instr_q    <= '0;
         newinstr_q <= 1'b0;
         halted_q   <= 1'b0;
      end else begin
         newinstr_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (bus.run)
                  state <= S_FETCH;
            end
            S_FETCH: begin
               if (rd_data[31:26] == OP_HALT) begin
                  state    <= S_HALT;
                  halted_q <= 1'b1;
               end else begin
                  state      <= S_ISSUE;
                  instr_q    <= rd_data;
                  newinstr_q <= 1'b1;
               end
            end
            S_ISSUE: begin
               cnt   <= CW'(EXEC_CYCLES - 1);
               state <= S_EXEC;
            end
            S_EXEC: begin
               if (cnt == '0) begin
                  pc_q  <= npc;
                  state <= bus.run ? S_FETCH : S_IDLE;
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
            S_HALT: begin
               state <= S_HALT;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.instrword = instr_q;
   assign bus.newinstr  = newinstr_q;
   assign bus.pc        = pc_q;
   assign bus.halted    = halted_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: next-PC vector table plus multi-cycle sequences.
module tb_mips_fetch_unit;

`ifdef FETCH_BRANCH_EN
   localparam bit BR_EN = 1'b1;
`else
   localparam bit BR_EN = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   mips_fetch_unit_if #(.IMEM_DEPTH(64)) bus ();

   mips_fetch_unit #(
      .IMEM_DEPTH  (64),
      .EXEC_CYCLES (4),
      .RESET_PC    (32'h0000_0000)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct {
      logic [31:0] instr;
      int unsigned idx;
      logic        br;
      logic [31:0] exp_pc;
   } vec_t;

   vec_t        vecs [8];
   logic [31:0] model [64];
   int          vectors = 0;
   int          miscompares = 0;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] filler(input int i);
      return 32'h0022_0020 | (32'(i) << 11);
   endfunction

   task automatic mem_write(input int idx, input logic [31:0] data);
      bus.imem_we    = 1'b1;
      bus.imem_waddr = 6'(idx);
      bus.imem_wdata = data;
      model[idx]     = data;
      tick();
      bus.imem_we    = 1'b0;
   endtask

   task automatic apply_reset();
      bus.run = 1'b0;
      rst     = 1'b1;
      tick();
      tick();
      rst     = 1'b0;
   endtask

   task automatic wait_pulse(input logic [31:0] want_pc, input int budget, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (bus.newinstr && bus.pc == want_pc)
            ok = 1'b1;
      end
   endtask

   task automatic wait_pc_change(input int budget, output bit ok);
      logic [31:0] start;
      start = bus.pc;
      ok = 1'b0;
      for (int i = 0; i < budget && !ok; i++) begin
         tick();
         if (bus.pc != start)
            ok = 1'b1;
      end
   endtask

   initial begin
      bit          ok;
      int          n;
      int          lat;
      int          cyc [8];
      logic [31:0] ppc [8];
      logic [31:0] pwd [8];
      logic [31:0] prog [5];

      // instr, index, br_eq, expected next PC (branch build : sequential build)
      vecs[0] = '{32'h1022_FFFE, 2, 1'b1, BR_EN ? 32'h0000_0004 : 32'h0000_000C};
      vecs[1] = '{32'h1022_FFFE, 2, 1'b0, 32'h0000_000C};
      vecs[2] = '{32'h0800_0010, 0, 1'b0, BR_EN ? 32'h0000_0040 : 32'h0000_0004};
      vecs[3] = '{32'h1022_0003, 1, 1'b1, BR_EN ? 32'h0000_0014 : 32'h0000_0008};
      vecs[4] = '{32'h0BFF_FFFF, 3, 1'b1, BR_EN ? 32'h0FFF_FFFC : 32'h0000_0010};
      vecs[5] = '{32'h8C22_0004, 2, 1'b1, 32'h0000_000C};
      vecs[6] = '{32'h1022_8000, 0, 1'b1, BR_EN ? 32'hFFFE_0004 : 32'h0000_0004};
      vecs[7] = '{32'hAC22_0008, 1, 1'b1, 32'h0000_0008};

      bus.run = 1'b0; bus.br_eq = 1'b0;
      bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = '0;

      // Reset values, sampled while reset is held.
      rst = 1'b1;
      #3;
      check("rst_pc", bus.pc, 32'h0);
      check("rst_instrword", bus.instrword, 32'h0);
      check("rst_newinstr", 32'(bus.newinstr), 32'h0);
      check("rst_halted", 32'(bus.halted), 32'h0);
      tick();
      rst = 1'b0;

      for (int i = 0; i < 64; i++)
         mem_write(i, filler(i));

      // Next-PC vector table.
      for (int v = 0; v < 8; v++) begin
         apply_reset();
         mem_write(int'(vecs[v].idx), vecs[v].instr);
         bus.br_eq = vecs[v].br;
         bus.run   = 1'b1;
         wait_pulse(32'(vecs[v].idx * 4), 200, ok);
         check($sformatf("v%0d_issue_seen", v), 32'(ok), 32'h1);
         check($sformatf("v%0d_instrword", v), bus.instrword, vecs[v].instr);
         wait_pc_change(20, ok);
         check($sformatf("v%0d_next_pc", v), bus.pc, vecs[v].exp_pc);
         wait_pulse(vecs[v].exp_pc, 20, ok);
         check($sformatf("v%0d_next_issue_seen", v), 32'(ok), 32'h1);
         check($sformatf("v%0d_next_word", v), bus.instrword, model[vecs[v].exp_pc[7:2]]);
         bus.run = 1'b0;
         bus.br_eq = 1'b0;
         mem_write(int'(vecs[v].idx), filler(int'(vecs[v].idx)));
      end

      // Drop run mid-window: window completes, PC advances, unit parks.
      apply_reset();
      bus.run = 1'b1;
      wait_pulse(32'h0, 20, ok);
      check("drop_first_issue", 32'(ok), 32'h1);
      tick();
      bus.run = 1'b0;
      n = 0;
      for (int i = 0; i < 12; i++) begin
         tick();
         if (bus.newinstr) n++;
      end
      check("drop_no_pulse", 32'(n), 32'h0);
      check("drop_pc_adv", bus.pc, 32'h4);
      bus.run = 1'b1;
      lat = -1;
      for (int i = 1; i <= 10 && lat < 0; i++) begin
         tick();
         if (bus.newinstr) lat = i;
      end
      check("resume_latency", 32'(lat), 32'h2);
      check("resume_pc", bus.pc, 32'h4);
      check("resume_word", bus.instrword, model[1]);

      // Reset in the second EXEC cycle at pc=8.
      apply_reset();
      bus.run = 1'b1;
      wait_pulse(32'h8, 50, ok);
      check("rstmid_issue_seen", 32'(ok), 32'h1);
      tick();
      tick();
      check("rstmid_pc_before", bus.pc, 32'h8);
      rst = 1'b1;
      #1;
      check("rstmid_pc", bus.pc, 32'h0);
      check("rstmid_instrword", bus.instrword, 32'h0);
      check("rstmid_newinstr", 32'(bus.newinstr), 32'h0);
      tick();
      rst = 1'b0;
      wait_pulse(32'h0, 20, ok);
      check("rstmid_refetch_seen", 32'(ok), 32'h1);
      check("rstmid_mem_kept0", bus.instrword, filler(0));
      wait_pulse(32'h8, 30, ok);
      check("rstmid_mem_kept2", bus.instrword, filler(2));
      bus.run = 1'b0;

      // Program with halt: four issues six cycles apart, then halt at pc=16.
      prog[0] = 32'h0109_5020; prog[1] = 32'h0109_5022;
      prog[2] = 32'h8D0A_0004; prog[3] = 32'hAD0A_0008;
      prog[4] = 32'hFC00_0000;
      apply_reset();
      for (int i = 0; i < 5; i++)
         mem_write(i, prog[i]);
      bus.run = 1'b1;
      n = 0;
      for (int i = 0; i < 8; i++) begin
         cyc[i] = 0; ppc[i] = '0; pwd[i] = '0;
      end
      for (int c = 1; c <= 60; c++) begin
         tick();
         if (bus.newinstr) begin
            if (n < 8) begin
               cyc[n] = c; ppc[n] = bus.pc; pwd[n] = bus.instrword;
            end
            n++;
         end
      end
      check("halt_pulse_count", 32'(n), 32'h4);
      check("halt_latency", 32'(cyc[0]), 32'h2);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("halt_pc%0d", k), ppc[k], 32'(4 * k));
         check($sformatf("halt_word%0d", k), pwd[k], prog[k]);
      end
      for (int k = 1; k < 4; k++)
         check($sformatf("halt_period%0d", k), 32'(cyc[k] - cyc[k-1]), 32'h6);
      check("halt_flag", 32'(bus.halted), 32'h1);
      check("halt_pc", bus.pc, 32'h10);
      check("halt_instrword_kept", bus.instrword, prog[3]);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
